raytracing_nios2_cpu_ocimem_ctrl: RTL and testbench

- Sysclk-domain debug memory controller directly downstream of the debug-slave sysclk decoder.
- Consumes the decoded JTAG command strobes and the 38-bit jdo payload.
- Executes read/write/address-load commands against a private on-chip debug RAM.
- Returns MonDReg/monitor_ready/monitor_error to the debug-slave TCK capture path.
- Arbitrates the same RAM against the CPU's Avalon-MM debug slave port; JTAG has priority.

---
 rtl/raytracing_nios2_cpu_ocimem_pkg.sv | 54 +++++
 rtl/raytracing_nios2_cpu_ocimem_ctrl_if.sv | 31 +++
 rtl/raytracing_nios2_cpu_ocimem_ram.sv | 35 +++
 rtl/raytracing_nios2_cpu_ocimem_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_raytracing_nios2_cpu_ocimem_ctrl.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/raytracing_nios2_cpu_ocimem_pkg.sv
// +----------------------------------------------------------------------+
// | raytracing_nios2_cpu_ocimem_pkg                                      |
// | Shared types and jdo field positions for the OCI debug memory ctrl.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package raytracing_nios2_cpu_ocimem_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    JRD     = 3'd1,
    JRD_CAP = 3'd2,
    JWR     = 3'd3,
    CRD     = 3'd4,
    CRD_CAP = 3'd5,
    CWR     = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } op_t;

  localparam int JDO_W            = 38;
  localparam int DATA_W           = 32;
  localparam int JDO_LOAD_BIT     = 35;
  localparam int JDO_PREFETCH_BIT = 34;
  localparam int JDO_WDATA_LSB    = 3;
  localparam int JDO_ADDR_LSB     = 2;

  // An address-only LOAD carries no RAM operation of its own.
  function automatic op_t decode_op(input logic act_a, input logic no_act_a,
                                    input logic act_b, input logic [JDO_W-1:0] j);
    op_t op;
    op = NONE;
    if (act_b) begin
      op = WRITE;
    end else if (no_act_a) begin
      op = READ;
    end else if (act_a) begin
      if (j[JDO_LOAD_BIT] && !j[JDO_PREFETCH_BIT]) begin
        op = NONE;
      end else begin
        op = READ;
      end
    end
    return op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/raytracing_nios2_cpu_ocimem_ctrl_if.sv
// +----------------------------------------------------------------------+
// | raytracing_nios2_cpu_ocimem_ctrl_if                                  |
// | Avalon-MM debug slave bundle between the CPU and the debug memory.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface raytracing_nios2_cpu_ocimem_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic              debugaccess;
  logic [31:0]       readdata;
  logic              waitrequest;

  modport master (
    output address, read, write, writedata, byteenable, debugaccess,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read, write, writedata, byteenable, debugaccess,
    output readdata, waitrequest
  );
endinterface

`default_nettype wire

// File: rtl/raytracing_nios2_cpu_ocimem_ram.sv
// +----------------------------------------------------------------------+
// | raytracing_nios2_cpu_ocimem_ram                                      |
// | Single-port 32-bit synchronous RAM, 1-cycle read, byte enables.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module raytracing_nios2_cpu_ocimem_ram #(
  parameter int    ADDR_W    = 8,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       q
);

  logic [31:0] r_mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          r_mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
    q <= r_mem[addr];
  end

endmodule

`default_nettype wire

// File: rtl/raytracing_nios2_cpu_ocimem_ctrl.sv
// +----------------------------------------------------------------------+
// | raytracing_nios2_cpu_ocimem_ctrl                                     |
// | JTAG debug command executor sharing a debug RAM with the CPU port.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module raytracing_nios2_cpu_ocimem_ctrl
  import raytracing_nios2_cpu_ocimem_pkg::*;
#(
  parameter int    ADDR_W    = 8,
  parameter string INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [JDO_W-1:0]     jdo,
  input  logic                 take_action_ocimem_a,
  input  logic                 take_no_action_ocimem_a,
  input  logic                 take_action_ocimem_b,
  raytracing_nios2_cpu_ocimem_ctrl_if.slave avs,
  output logic [DATA_W-1:0]    MonDReg,
  output logic [ADDR_W-1:0]    MonAReg,
  output logic                 monitor_ready,
  output logic                 monitor_error
);

  state_t              r_state;
  state_t              w_next;
  logic                r_slot_valid;
  op_t                 r_slot_op;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_readdata;
  logic [ADDR_W-1:0]   r_mon_a;
  logic [DATA_W-1:0]   r_mon_d;
  logic                r_err;

  logic                w_strobe;
  logic                w_load;
  op_t                 w_cmd_op;
  logic                w_drop;
  logic                w_accept;
  logic                w_direct;
  logic                w_to_slot;

  logic [ADDR_W-1:0]   w_ram_addr;
  logic                w_ram_we;
  logic [3:0]          w_ram_be;
  logic [DATA_W-1:0]   w_ram_wdata;
  logic [DATA_W-1:0]   w_ram_q;
  logic                w_waitrequest;
  logic                w_ready;
  logic                w_unused_jdo;

  assign w_unused_jdo = ^{jdo[37:36], jdo[1:0]};

  // A strobe seen in IDLE with an empty slot dispatches straight to the FSM;
  // otherwise it waits in the single slot, or is dropped if that is taken.
  always_comb begin
    w_strobe  = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    w_load    = take_action_ocimem_a & jdo[JDO_LOAD_BIT];
    w_cmd_op  = decode_op(take_action_ocimem_a, take_no_action_ocimem_a,
                          take_action_ocimem_b, jdo);
    w_drop    = w_strobe & r_slot_valid;
    w_accept  = w_strobe & ~r_slot_valid;
    w_direct  = w_accept & (w_cmd_op != NONE) & (r_state == IDLE);
    w_to_slot = w_accept & (w_cmd_op != NONE) & (r_state != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (r_slot_valid) begin
          w_next = (r_slot_op == WRITE) ? JWR : JRD;
        end else if (w_direct) begin
          w_next = (w_cmd_op == WRITE) ? JWR : JRD;
        end else if (avs.read) begin
          w_next = CRD;
        end else if (avs.write) begin
          w_next = CWR;
        end
      end
      JRD:     w_next = JRD_CAP;
      JRD_CAP: w_next = IDLE;
      JWR:     w_next = IDLE;
      CRD:     w_next = CRD_CAP;
      CRD_CAP: w_next = IDLE;
      CWR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_ram_addr    = avs.address;
    w_ram_we      = 1'b0;
    w_ram_be      = avs.byteenable;
    w_ram_wdata   = avs.writedata;
    case (r_state)
      JRD: begin
        w_ram_addr = r_mon_a;
      end
      JWR: begin
        w_ram_addr  = r_mon_a;
        w_ram_we    = 1'b1;
        w_ram_be    = 4'hF;
        w_ram_wdata = r_wdata;
      end
      CWR: begin
        w_ram_we = avs.debugaccess;
      end
      default: ;
    endcase
    w_waitrequest = (avs.read | avs.write) & ~((r_state == CRD_CAP) | (r_state == CWR));
    w_ready       = ~r_slot_valid &
                    ~((r_state == JRD) | (r_state == JRD_CAP) | (r_state == JWR));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_slot_valid <= 1'b0;
      r_slot_op    <= NONE;
      r_wdata      <= '0;
      r_readdata   <= '0;
      r_mon_a      <= '0;
      r_mon_d      <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_to_slot) begin
        r_slot_valid <= 1'b1;
        r_slot_op    <= w_cmd_op;
      end else if ((r_state == IDLE) && r_slot_valid) begin
        r_slot_valid <= 1'b0;
        r_slot_op    <= NONE;
      end

      // Only one JTAG write can be accepted before JWR consumes this value.
      if ((w_direct | w_to_slot) && (w_cmd_op == WRITE)) begin
        r_wdata <= jdo[JDO_WDATA_LSB +: DATA_W];
      end

      if (w_accept && w_load) begin
        r_mon_a <= jdo[JDO_ADDR_LSB +: ADDR_W];
      end else if ((r_state == JRD_CAP) || (r_state == JWR)) begin
        r_mon_a <= r_mon_a + ADDR_W'(1);
      end

      if (r_state == JRD_CAP) begin
        r_mon_d <= w_ram_q;
      end

      if (r_state == CRD_CAP) begin
        r_readdata <= w_ram_q;
      end

      if (w_drop) begin
        r_err <= 1'b1;
      end else if (w_accept && w_load) begin
        r_err <= 1'b0;
      end
    end
  end

  raytracing_nios2_cpu_ocimem_ram #(
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .addr  (w_ram_addr),
    .we    (w_ram_we),
    .be    (w_ram_be),
    .wdata (w_ram_wdata),
    .q     (w_ram_q)
  );

  // Read data is presented straight from the RAM in the cycle the stall drops.
  assign avs.readdata    = (r_state == CRD_CAP) ? w_ram_q : r_readdata;
  assign avs.waitrequest = w_waitrequest;
  assign MonDReg         = r_mon_d;
  assign MonAReg         = r_mon_a;
  assign monitor_ready   = w_ready;
  assign monitor_error   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_raytracing_nios2_cpu_ocimem_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_raytracing_nios2_cpu_ocimem_ctrl                                  |
// | Directed vector bench for the OCI debug memory controller.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_raytracing_nios2_cpu_ocimem_ctrl;

  localparam int K_LOAD = 0;
  localparam int K_RDA  = 1;
  localparam int K_RDN  = 2;
  localparam int K_WR   = 3;
  localparam int NVEC   = 10;

  typedef struct {
    int          kind;
    logic        pf;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic [7:0]  exp_a;
    logic [31:0] exp_d;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [37:0] jdo = '0;
  logic        sa = 1'b0;
  logic        sn = 1'b0;
  logic        sb = 1'b0;
  logic [31:0] MonDReg;
  logic [7:0]  MonAReg;
  logic        monitor_ready;
  logic        monitor_error;

  int n_cmp  = 0;
  int n_fail = 0;
  vec_t vecs [NVEC];

  raytracing_nios2_cpu_ocimem_ctrl_if #(.ADDR_W(8)) avs ();

  raytracing_nios2_cpu_ocimem_ctrl #(
    .ADDR_W    (8),
    .INIT_FILE ("")
  ) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (sa),
    .take_no_action_ocimem_a (sn),
    .take_action_ocimem_b    (sb),
    .avs                     (avs),
    .MonDReg                 (MonDReg),
    .MonAReg                 (MonAReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] mk_jdo(input int kind, input logic pf,
                                         input logic [7:0] addr, input logic [31:0] wd);
    logic [37:0] j;
    j = '0;
    if (kind == K_LOAD) begin
      j[35]  = 1'b1;
      j[34]  = pf;
      j[9:2] = addr;
    end else if (kind == K_WR) begin
      j[34:3] = wd;
    end
    return j;
  endfunction

  task automatic issue(input int kind, input logic [37:0] j);
    jdo = j;
    sa  = (kind == K_LOAD) || (kind == K_RDA);
    sn  = (kind == K_RDN);
    sb  = (kind == K_WR);
    tick;
    sa  = 1'b0;
    sn  = 1'b0;
    sb  = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] addr, output logic [31:0] data, output int n);
    avs.address = addr;
    avs.read    = 1'b1;
    n = 0;
    #1;
    while (avs.waitrequest && n < 20) begin
      tick;
      n++;
    end
    data     = avs.readdata;
    avs.read = 1'b0;
    tick;
  endtask

  task automatic cpu_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] be, input logic da, output int n);
    avs.address     = addr;
    avs.writedata   = data;
    avs.byteenable  = be;
    avs.debugaccess = da;
    avs.write       = 1'b1;
    n = 0;
    #1;
    while (avs.waitrequest && n < 20) begin
      tick;
      n++;
    end
    avs.write = 1'b0;
    tick;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          n;
    int          extra;

    avs.address     = '0;
    avs.read        = 1'b0;
    avs.write       = 1'b0;
    avs.writedata   = '0;
    avs.byteenable  = '0;
    avs.debugaccess = 1'b0;

    vecs[0] = '{K_LOAD, 1'b0, 8'h10, 32'h0,        8'h10, 32'h0,        1'b0};
    vecs[1] = '{K_WR,   1'b0, 8'h00, 32'hDEADBEEF, 8'h11, 32'h0,        1'b0};
    vecs[2] = '{K_WR,   1'b0, 8'h00, 32'h11111111, 8'h12, 32'h0,        1'b0};
    vecs[3] = '{K_LOAD, 1'b1, 8'h10, 32'h0,        8'h11, 32'hDEADBEEF, 1'b0};
    vecs[4] = '{K_RDN,  1'b0, 8'h00, 32'h0,        8'h12, 32'h11111111, 1'b0};
    vecs[5] = '{K_LOAD, 1'b0, 8'hFF, 32'h0,        8'hFF, 32'h11111111, 1'b0};
    vecs[6] = '{K_WR,   1'b0, 8'h00, 32'hA5A5A5A5, 8'h00, 32'h11111111, 1'b0};
    vecs[7] = '{K_LOAD, 1'b1, 8'hFF, 32'h0,        8'h00, 32'hA5A5A5A5, 1'b0};
    vecs[8] = '{K_LOAD, 1'b0, 8'h11, 32'h0,        8'h11, 32'hA5A5A5A5, 1'b0};
    vecs[9] = '{K_RDA,  1'b0, 8'h00, 32'h0,        8'h12, 32'h11111111, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick;
    check("rst_areg",  32'(MonAReg), 32'h0);
    check("rst_dreg",  MonDReg, 32'h0);
    check("rst_ready", 32'(monitor_ready), 32'h1);
    check("rst_err",   32'(monitor_error), 32'h0);
    check("rst_rdata", avs.readdata, 32'h0);
    check("rst_wait",  32'(avs.waitrequest), 32'h0);

    for (int i = 0; i < NVEC; i++) begin
      issue(vecs[i].kind, mk_jdo(vecs[i].kind, vecs[i].pf, vecs[i].addr, vecs[i].wd));
      if (!(vecs[i].kind == K_LOAD && !vecs[i].pf)) begin
        check($sformatf("v%0d_busy", i), 32'(monitor_ready), 32'h0);
      end
      if (vecs[i].kind == K_WR)                        extra = 1;
      else if (vecs[i].kind == K_LOAD && !vecs[i].pf)  extra = 0;
      else                                             extra = 2;
      repeat (extra) tick;
      check($sformatf("v%0d_areg", i),  32'(MonAReg), 32'(vecs[i].exp_a));
      check($sformatf("v%0d_dreg", i),  MonDReg, vecs[i].exp_d);
      check($sformatf("v%0d_ready", i), 32'(monitor_ready), 32'h1);
      check($sformatf("v%0d_err", i),   32'(monitor_error), 32'(vecs[i].exp_err));
    end

    // JTAG write and CPU read collide in IDLE: JTAG goes first.
    issue(K_LOAD, mk_jdo(K_LOAD, 1'b0, 8'h10, 32'h0));
    avs.address = 8'h10;
    avs.read    = 1'b1;
    jdo         = mk_jdo(K_WR, 1'b0, 8'h00, 32'h12345678);
    sb          = 1'b1;
    #1;
    check("arb_wait0", 32'(avs.waitrequest), 32'h1);
    tick;
    sb = 1'b0;
    n  = 1;
    while (avs.waitrequest && n < 20) begin
      tick;
      n++;
    end
    check("arb_lat",   32'(n), 32'd4);
    check("arb_rdata", avs.readdata, 32'h12345678);
    check("arb_areg",  32'(MonAReg), 32'h11);
    avs.read = 1'b0;
    tick;
    check("arb_hold",  avs.readdata, 32'h12345678);

    // CPU writes: discarded without debugaccess, byte-lane merge with it.
    cpu_write(8'h10, 32'hCAFEF00D, 4'hF, 1'b0, n);
    check("cwr0_lat", 32'(n), 32'd1);
    cpu_read(8'h10, rd, n);
    check("crd0_lat", 32'(n), 32'd2);
    check("cwr0_ram", rd, 32'h12345678);
    cpu_write(8'h10, 32'hCAFEF00D, 4'b0011, 1'b1, n);
    check("cwr1_lat", 32'(n), 32'd1);
    cpu_read(8'h10, rd, n);
    check("cwr1_ram", rd, 32'h1234F00D);

    // Three back-to-back strobes against a pending CPU read.
    issue(K_LOAD, mk_jdo(K_LOAD, 1'b0, 8'h10, 32'h0));
    avs.address = 8'h10;
    avs.read    = 1'b1;
    jdo         = '0;
    sn          = 1'b1;
    tick;
    tick;
    tick;
    sn = 1'b0;
    check("ovr_err",   32'(monitor_error), 32'h1);
    check("ovr_first", MonDReg, 32'h1234F00D);
    check("ovr_ready", 32'(monitor_ready), 32'h0);
    n = 3;
    while (avs.waitrequest && n < 30) begin
      tick;
      n++;
    end
    check("ovr_cpu_lat",   32'(n), 32'd8);
    check("ovr_cpu_rdata", avs.readdata, 32'h1234F00D);
    avs.read = 1'b0;
    tick;
    check("ovr_dreg",  MonDReg, 32'h11111111);
    check("ovr_areg",  32'(MonAReg), 32'h12);
    check("ovr_err2",  32'(monitor_error), 32'h1);
    issue(K_LOAD, mk_jdo(K_LOAD, 1'b0, 8'h10, 32'h0));
    check("load_clr_err", 32'(monitor_error), 32'h0);

    // Asynchronous reset while a JTAG read is in JRD.
    issue(K_RDN, '0);
    reset_n = 1'b0;
    #1;
    check("arst_areg",  32'(MonAReg), 32'h0);
    check("arst_dreg",  MonDReg, 32'h0);
    check("arst_ready", 32'(monitor_ready), 32'h1);
    check("arst_err",   32'(monitor_error), 32'h0);
    check("arst_rdata", avs.readdata, 32'h0);
    tick;
    tick;
    reset_n = 1'b1;
    tick;
    issue(K_LOAD, mk_jdo(K_LOAD, 1'b1, 8'h10, 32'h0));
    tick;
    tick;
    check("post_rst_dreg", MonDReg, 32'h1234F00D);
    check("post_rst_areg", 32'(MonAReg), 32'h11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
